// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD countdown timer and its digit cells.
package bcd_pkg;

   typedef enum logic [1:0] {StIdle, StRun, StHold, StDone} state_t;

   localparam logic [3:0] BCD_MAX  = 4'd9;
   localparam logic [3:0] BCD_ZERO = 4'd0;

   // Non-BCD nibbles (A..F) saturate to 9 so the counter never holds an illegal digit.
   function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
      return (d > BCD_MAX) ? BCD_MAX : d;
   endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD digit of the down-counter: synchronous load, decrement with 0 -> 9 wrap.
module bcd_down_digit
   import bcd_pkg::*;
(
   input  logic       clk,
   input  logic       ar,
   input  logic       ld,
   input  logic [3:0] ld_val,
   input  logic       dec_in,
   output logic [3:0] q,
   output logic       is_zero
);

   always_ff @(posedge clk) begin
      if (ar) begin
         q <= BCD_ZERO;
      end else if (ld) begin
         q <= ld_val;
      end else if (dec_in) begin
         q <= (q == BCD_ZERO) ? BCD_MAX : q - 4'd1;
      end
   end

   assign is_zero = (q == BCD_ZERO);

endmodule

// File: rtl/bcd_down_timer.sv
// Multi-digit BCD countdown timer with start/stop control and terminal-count pulse.
// Optional periodic mode: define BCD_TIMER_AUTO_RELOAD_EN.
module bcd_down_timer
   import bcd_pkg::*;
#(
   parameter int unsigned DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  ar,
   input  logic                  tick,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   input  logic                  start,
   input  logic                  stop,
   output logic [4*DIGITS-1:0]   q,
   output logic                  running,
   output logic                  done,
   output logic                  tc_pulse
);

   state_t              state_q;
   logic [DIGITS-1:0]   is_zero;
   logic [DIGITS-1:0]   dec_in;
   logic [DIGITS:0]     lower_zero;
   logic                upper_zero;
   logic                all_zero;
   logic                q_one;
   logic                dec_en;
   logic                reload;
   logic                ld;
   logic [4*DIGITS-1:0] clamped_val;
   logic [4*DIGITS-1:0] ld_bus;

   always_comb begin
      lower_zero    = '0;
      lower_zero[0] = 1'b1;
      upper_zero    = 1'b1;
      clamped_val   = '0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         lower_zero[i+1]       = lower_zero[i] & is_zero[i];
         clamped_val[4*i +: 4] = bcd_clamp(load_val[4*i +: 4]);
         if (i > 0) upper_zero = upper_zero & is_zero[i];
      end
   end

   assign all_zero = lower_zero[DIGITS];
   assign q_one    = upper_zero & (q[3:0] == 4'd1);
   // Stop and load both outrank the count strobe at the same edge.
   assign dec_en   = tick & (state_q == StRun) & ~load & ~stop & ~all_zero;

   always_comb begin
      dec_in = '0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         dec_in[i] = dec_en & lower_zero[i];
      end
   end

`ifdef BCD_TIMER_AUTO_RELOAD_EN
   logic [4*DIGITS-1:0] preset_q;

   always_ff @(posedge clk) begin
      if (ar) begin
         preset_q <= '0;
      end else if (load) begin
         preset_q <= clamped_val;
      end
   end

   assign reload = tick & (state_q == StRun) & ~load & ~stop & all_zero;
   assign ld_bus = load ? clamped_val : preset_q;
`else
   assign reload = 1'b0;
   assign ld_bus = clamped_val;
`endif

   assign ld = load | reload;

   for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      bcd_down_digit u_digit (
         .clk     (clk),
         .ar      (ar),
         .ld      (ld),
         .ld_val  (ld_bus[4*i +: 4]),
         .dec_in  (dec_in[i]),
         .q       (q[4*i +: 4]),
         .is_zero (is_zero[i])
      );
   end

   always_ff @(posedge clk) begin
      if (ar) begin
         state_q  <= StIdle;
         running  <= 1'b0;
         done     <= 1'b0;
         tc_pulse <= 1'b0;
      end else begin
         tc_pulse <= 1'b0;
         if (load) begin
            state_q <= StIdle;
            running <= 1'b0;
            done    <= 1'b0;
         end else begin
            unique case (state_q)
               StIdle, StHold: begin
                  if (start && !stop) begin
`ifdef BCD_TIMER_AUTO_RELOAD_EN
                     state_q <= StRun;
                     running <= 1'b1;
`else
                     if (all_zero) begin
                        state_q <= StDone;
                        done    <= 1'b1;
                     end else begin
                        state_q <= StRun;
                        running <= 1'b1;
                     end
`endif
                  end
               end
               StRun: begin
                  if (stop) begin
                     state_q <= StHold;
                     running <= 1'b0;
                  end else if (tick && q_one) begin
                     tc_pulse <= 1'b1;
`ifndef BCD_TIMER_AUTO_RELOAD_EN
                     state_q  <= StDone;
                     running  <= 1'b0;
                     done     <= 1'b1;
`endif
                  end
               end
               StDone: begin
                  if (start && !stop && !all_zero) begin
                     state_q <= StRun;
                     running <= 1'b1;
                     done    <= 1'b0;
                  end
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_bcd_down_timer.sv
// Directed self-checking bench for bcd_down_timer (DIGITS=4).
module tb_bcd_down_timer;

   logic        clk = 1'b0;
   logic        ar, tick, load, start, stop;
   logic [15:0] load_val;
   logic [15:0] q;
   logic        running, done, tc_pulse;
   int          n_cmp = 0;
   int          n_err = 0;

   bcd_down_timer #(.DIGITS(4)) dut (
      .clk      (clk),
      .ar       (ar),
      .tick     (tick),
      .load     (load),
      .load_val (load_val),
      .start    (start),
      .stop     (stop),
      .q        (q),
      .running  (running),
      .done     (done),
      .tc_pulse (tc_pulse)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      ar = 0; tick = 0; load = 0; start = 0; stop = 0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_load(input logic [15:0] v);
      idle_in(); load = 1; load_val = v; cyc(); idle_in();
   endtask

   task automatic do_start();
      idle_in(); start = 1; cyc(); idle_in();
   endtask

   task automatic do_tick();
      idle_in(); tick = 1; cyc(); idle_in();
   endtask

   initial begin
      logic [15:0] exp_q;
      int          tc_count;

      // 1: reset dominates everything else
      idle_in();
      ar = 1; load = 1; load_val = 16'h1234; start = 1; tick = 1;
      cyc();
      idle_in();
      chk("rst_q", q, 16'h0000);
      chk("rst_running", running, 0);
      chk("rst_done", done, 0);
      chk("rst_tc", tc_pulse, 0);

`ifndef BCD_TIMER_AUTO_RELOAD_EN
      // 2: 10 ticks from 0010
      do_load(16'h0010);
      do_start();
      chk("t2_running", running, 1);
      for (int i = 0; i < 10; i++) begin
         do_tick();
         exp_q = (i == 0) ? 16'h0009 : 16'(9 - i);
         chk("t2_q", q, exp_q);
         chk("t2_tc", tc_pulse, (i == 9) ? 1 : 0);
      end
      chk("t2_done", done, 1);
      chk("t2_running_end", running, 0);
      cyc();
      chk("t2_tc_clear", tc_pulse, 0);
      chk("t2_done_hold", done, 1);
      do_tick();
      chk("t2_q_stays0", q, 16'h0000);

      // start with q==0 goes straight to DONE, no pulse
      do_load(16'h0000);
      chk("zero_done_clr", done, 0);
      do_start();
      chk("zero_start_done", done, 1);
      chk("zero_start_tc", tc_pulse, 0);
      chk("zero_start_run", running, 0);
`endif

      // 3: three-digit borrow in one cycle
      do_load(16'h1000);
      do_start();
      do_tick();
      chk("t3_q", q, 16'h0999);

      // 4: stop/hold/resume
      do_load(16'h0005);
      do_start();
      do_tick();
      do_tick();
      chk("t4_q_run", q, 16'h0003);
      idle_in(); stop = 1; tick = 1; cyc(); idle_in();
      chk("t4_stop_tick", q, 16'h0003);
      chk("t4_hold_running", running, 0);
      for (int i = 0; i < 3; i++) do_tick();
      chk("t4_q_hold", q, 16'h0003);
      idle_in(); start = 1; stop = 1; cyc(); idle_in();
      chk("t4_stop_wins", running, 0);
      do_start();
      chk("t4_resume", running, 1);
      do_tick();
      chk("t4_q_after", q, 16'h0002);

      // reset mid-count
      idle_in(); ar = 1; tick = 1; cyc(); idle_in();
      chk("rst_mid_q", q, 16'h0000);
      chk("rst_mid_running", running, 0);

      // 5: load beats tick; clamp of non-BCD nibbles
      do_load(16'h0003);
      do_start();
      idle_in(); load = 1; load_val = 16'h0042; tick = 1; cyc(); idle_in();
      chk("t5_q", q, 16'h0042);
      chk("t5_idle", running, 0);
      do_tick();
      chk("t5_idle_tick", q, 16'h0042);
      do_load(16'h00F7);
      chk("t5_clamp", q, 16'h0097);
      do_load(16'hFA3B);
      chk("t5_clamp_all", q, 16'h9939);

`ifdef BCD_TIMER_AUTO_RELOAD_EN
      // 6: periodic mode
      do_load(16'h0002);
      do_start();
      tc_count = 0;
      for (int i = 0; i < 6; i++) begin
         do_tick();
         exp_q = 16'((i % 3 == 0) ? 1 : (i % 3 == 1) ? 0 : 2);
         chk("t6_q", q, exp_q);
         chk("t6_tc", tc_pulse, (i % 3 == 1) ? 1 : 0);
         chk("t6_done", done, 0);
         chk("t6_running", running, 1);
         if (tc_pulse) tc_count++;
      end
      chk("t6_tc_count", tc_count, 2);
      idle_in(); ar = 1; cyc(); idle_in();
      chk("t6_rst_q", q, 16'h0000);
      chk("t6_rst_running", running, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
